// File: rtl/alu_result_sel_pipe_if.sv
// rtl/alu_result_sel_pipe_if.sv - handshake bundle for alu_result_sel_pipe
// Optional out_zero/out_neg exist only when ALU_SEL_FLAGS_EN is defined.
interface alu_result_sel_pipe_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 16,
  parameter int LOAD_W = 4
);
  localparam int SEL_W = ($clog2(NUM_CH) < 1) ? 1 : $clog2(NUM_CH);

  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [LOAD_W-1:0]       load;
  logic [SEL_W-1:0]        sel;
  logic                    enable;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_err;
  logic                    out_valid;
  logic                    out_ready;
`ifdef ALU_SEL_FLAGS_EN
  logic                    out_zero;
  logic                    out_neg;

  modport master (
    output in_data, load, sel, enable, in_valid, out_ready,
    input  in_ready, out_data, out_err, out_valid, out_zero, out_neg
  );
  modport slave (
    input  in_data, load, sel, enable, in_valid, out_ready,
    output in_ready, out_data, out_err, out_valid, out_zero, out_neg
  );
`else
  modport master (
    output in_data, load, sel, enable, in_valid, out_ready,
    input  in_ready, out_data, out_err, out_valid
  );
  modport slave (
    input  in_data, load, sel, enable, in_valid, out_ready,
    output in_ready, out_data, out_err, out_valid
  );
`endif
endinterface

// File: rtl/alu_result_sel_pipe.sv
// rtl/alu_result_sel_pipe.sv - registered ALU result select with one-entry skid buffer
// Optional zero/negative flags: define ALU_SEL_FLAGS_EN.
module alu_result_sel_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 16,
  parameter int LOAD_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_result_sel_pipe_if.slave bus
);
  localparam int SEL_W = ($clog2(NUM_CH) < 1) ? 1 : $clog2(NUM_CH);

  typedef struct packed {
`ifdef ALU_SEL_FLAGS_EN
    logic             zero;
    logic             neg;
`endif
    logic             err;
    logic [WIDTH-1:0] data;
  } beat_t;

  // Encoding mirrors {skid_valid, out_valid}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t state_q, state_d;
  beat_t  out_q, out_d;
  beat_t  skid_q, skid_d;
  beat_t  result;
  logic   hit;
  logic   in_xfer;
  logic   out_xfer;

  always_comb begin
    result = '0;
    hit    = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (bus.sel == SEL_W'(k)) begin
        hit = 1'b1;
        if (bus.enable) result.data = bus.in_data[k*WIDTH +: WIDTH];
      end
    end
    if (!bus.enable) begin
      result.data[LOAD_W-1:0] = bus.load;
    end else if (!hit) begin
      result.err = 1'b1;
    end
`ifdef ALU_SEL_FLAGS_EN
    result.zero = (result.data == '0);
    result.neg  = result.data[WIDTH-1];
`endif
  end

  assign bus.in_ready  = (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);
  assign in_xfer       = bus.in_valid && bus.in_ready;
  assign out_xfer      = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          out_d   = result;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          out_d = result;
        end else if (in_xfer) begin
          skid_d  = result;
          state_d = FULL;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          out_d   = skid_q;
          skid_d  = '0;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.out_data = out_q.data;
  assign bus.out_err  = out_q.err;
`ifdef ALU_SEL_FLAGS_EN
  assign bus.out_zero = out_q.zero;
  assign bus.out_neg  = out_q.neg;
`endif
endmodule

// File: doc/alu_result_sel_pipe.md
Name: alu_result_sel_pipe

Overview:
- Parametrised, registered successor to the ALU result multiplexer.
- Selects one of NUM_CH operation results, or the zero-extended LOAD value when enable is low.
- Registers the selection and carries it through a valid/ready handshake with a one-entry skid buffer, so downstream back-pressure never drops a result.
- Sits between the ALU operation units and the accumulator/register-file write port.

Parameters:
- WIDTH, 8, bit width of each result channel and of out_data.
- NUM_CH, 16, number of result channels (2..64); SEL_W = max(1, clog2(NUM_CH)) is a localparam.
- LOAD_W, 4, width of the load input (1..WIDTH); zero-extended to WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_data  input  NUM_CH*WIDTH  packed results; channel k occupies bits [k*WIDTH +: WIDTH].
- load  input  LOAD_W  load value, used when enable=0.
- sel  input  SEL_W  channel select.
- enable  input  1  1 = select channel sel; 0 = select load.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- out_data  output  WIDTH  registered result.
- out_err  output  1  result came from out-of-range sel.
- out_valid  output  1  out_data/out_err valid.
- out_ready  input  1  downstream accepts.

Behaviour:
- Reset: synchronous on a clk edge with rst_n=0.
  - out_data=0, out_err=0, out_valid=0.
  - Skid entry cleared, so in_ready=1 on the first cycle after reset.
  - Any beat in flight is discarded; reset mid-stall drops both stored beats.
  - Beats presented while rst_n=0 are ignored.
- Combinational select (pre-register), called result:
  - enable=0: {zeros, load}, err=0.
  - enable=1 and sel<NUM_CH: channel sel, err=0.
  - enable=1 and sel>=NUM_CH: all zeros, err=1.
- Handshake:
  - Input transfer on in_valid&&in_ready.
  - Output transfer on out_valid&&out_ready.
  - in_ready = !skid_valid (registered state, no combinational path from out_ready).
- Two storage slots: output register (OUT) and skid register (SKID). State is encoded by {skid_valid, out_valid}.
  - EMPTY (0,0): input transfer loads OUT; next state ONE.
  - ONE (0,1):
    - Input and output transfer together: OUT reloads with the new beat; stay ONE.
    - Input transfer only: beat goes to SKID; next state FULL.
    - Output transfer only: next state EMPTY.
  - FULL (1,1): in_ready=0.
    - Output transfer: OUT takes SKID contents, SKID is cleared; next state ONE.
    - Otherwise hold.
- Latency: 1 cycle from input transfer to out_valid when not stalled.
- Throughput: 1 beat/cycle with out_ready held high.
- Ordering: strict FIFO; no beat is duplicated or dropped.
- OUT and SKID hold their values while stalled. out_data is stable whenever out_valid=1 and out_ready=0.
- in_data/sel/enable/load are sampled only on the input transfer cycle.

Optional Feature:
- Macro: ALU_SEL_FLAGS_EN.
- Defined: adds output ports out_zero (1) and out_neg (1), registered alongside out_data through the same OUT/SKID path.
  - out_zero = (result==0).
  - out_neg = result[WIDTH-1].
  - Both reset to 0.
  - An out_err beat reports out_zero=1 and out_neg=0.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, out_data=0, out_err=0; in_ready=1 on the first cycle after release; no beat emitted.
- Channel sweep: defaults, channel k = 8'h10+k, out_ready=1, send enable=1 with sel=0..15 back-to-back -> out_data 8'h10..8'h1F in order, each one cycle after its input, out_valid high continuously.
- Load path: enable=0, load=4'hA, sel=4'h3 -> out_data=8'h0A, out_err=0.
- Back-pressure: out_ready=0, send beats 8'h21, 8'h22 -> in_ready falls after the second beat and stays low. A third beat held on in_valid is not taken. Raise out_ready -> outputs 8'h21, 8'h22, 8'h23 in order with no loss or duplication.
- Out-of-range: NUM_CH=5, enable=1, sel=3'd6 -> out_data=0, out_err=1. With ALU_SEL_FLAGS_EN defined, also out_zero=1, out_neg=0.
- Reset mid-stall: FULL state with out_ready=0, pulse rst_n=0 for one cycle -> next cycle out_valid=0, in_ready=1; the two stored beats are never emitted.
